// File: rtl/ili9341_init_seq_if.sv
// Interface for the ILI9341 power-up sequencer. It groups start control,
// the panel-reset handshake, the SPI byte stream and the status outputs.
`timescale 1ns/1ps
interface ili9341_init_seq_if;
    logic       i_start;
    logic       o_reset_ena;
    logic       o_reset_val;
    logic       i_reset_sent;
    logic       o_spi_valid;
    logic       o_spi_dc;
    logic [7:0] o_spi_data;
    logic       i_spi_ready;
    logic       i_spi_done;
    logic       o_busy;
    logic       o_init_done;
    logic [3:0] o_cmd_idx;

    modport master (
        input  i_start, i_reset_sent, i_spi_ready, i_spi_done,
        output o_reset_ena, o_reset_val, o_spi_valid, o_spi_dc, o_spi_data,
               o_busy, o_init_done, o_cmd_idx
    );

    modport slave (
        output i_start, i_reset_sent, i_spi_ready, i_spi_done,
        input  o_reset_ena, o_reset_val, o_spi_valid, o_spi_dc, o_spi_data,
               o_busy, o_init_done, o_cmd_idx
    );
endinterface

// File: rtl/ili9341_init_seq.sv
// ILI9341 power-up sequencer: requests a panel reset, then walks a fixed
// command table, sending SPI bytes and timing millisecond delays.
`timescale 1ns/1ps
module ili9341_init_seq #(
    parameter int CLK_PER_MS = 4000,
    parameter int ROM_DEPTH  = 16
) (
    input  logic clk,
    input  logic rst,
    ili9341_init_seq_if.master bus
);
    localparam int IDX_W = $clog2(ROM_DEPTH);
    localparam int SUB_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

    localparam logic [1:0] T_CMD   = 2'b00;
    localparam logic [1:0] T_DATA  = 2'b01;
    localparam logic [1:0] T_DELAY = 2'b10;
    localparam logic [1:0] T_END   = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_REQ,
        S_RST_WAIT,
        S_FETCH,
        S_DECODE,
        S_SEND,
        S_XFER,
        S_DELAY,
        S_DONE
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [9:0]         word, word_n;
    logic [7:0]         ms_cnt, ms_n;
    logic [SUB_W-1:0]   sub_cnt, sub_n;

    // The last table slot always reads as END so the index can never wrap.
    function automatic logic [9:0] rom_read(input logic [IDX_W-1:0] a);
        logic [9:0] w;
        case (int'(a))
            0:       w = {T_CMD,   8'h01};
            1:       w = {T_DELAY, 8'd5};
            2:       w = {T_CMD,   8'h28};
            3:       w = {T_CMD,   8'h3A};
            4:       w = {T_DATA,  8'h55};
            5:       w = {T_CMD,   8'h36};
            6:       w = {T_DATA,  8'h48};
            7:       w = {T_CMD,   8'h11};
            8:       w = {T_DELAY, 8'd120};
            9:       w = {T_CMD,   8'h29};
            default: w = {T_END,   8'h00};
        endcase
        if (int'(a) >= ROM_DEPTH - 1) begin
            w = {T_END, 8'h00};
        end
        return w;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            word    <= '0;
            ms_cnt  <= '0;
            sub_cnt <= '0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            word    <= word_n;
            ms_cnt  <= ms_n;
            sub_cnt <= sub_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        word_n  = word;
        ms_n    = ms_cnt;
        sub_n   = sub_cnt;
        case (state)
            S_IDLE, S_DONE: begin
                if (bus.i_start) begin
                    state_n = S_RST_REQ;
                    idx_n   = '0;
                end
            end
            S_RST_REQ: state_n = S_RST_WAIT;
            S_RST_WAIT: begin
                if (bus.i_reset_sent) begin
                    state_n = S_FETCH;
                end
            end
            S_FETCH: begin
                word_n  = rom_read(idx);
                state_n = S_DECODE;
            end
            S_DECODE: begin
                case (word[9:8])
                    T_CMD, T_DATA: state_n = S_SEND;
                    T_DELAY: begin
                        if (word[7:0] == 8'd0) begin
                            idx_n   = idx + 1'b1;
                            state_n = S_FETCH;
                        end else begin
                            ms_n    = word[7:0];
                            sub_n   = SUB_W'(CLK_PER_MS - 1);
                            state_n = S_DELAY;
                        end
                    end
                    default: state_n = S_DONE;
                endcase
            end
            S_SEND: begin
                if (bus.i_spi_ready) begin
                    state_n = S_XFER;
                end
            end
            S_XFER: begin
                if (bus.i_spi_done) begin
                    idx_n   = idx + 1'b1;
                    state_n = S_FETCH;
                end
            end
            // Each millisecond is CLK_PER_MS cycles of the sub counter.
            S_DELAY: begin
                if (sub_cnt == '0) begin
                    if (ms_cnt == 8'd1) begin
                        idx_n   = idx + 1'b1;
                        state_n = S_FETCH;
                    end else begin
                        ms_n  = ms_cnt - 8'd1;
                        sub_n = SUB_W'(CLK_PER_MS - 1);
                    end
                end else begin
                    sub_n = sub_cnt - 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.o_reset_ena = (state == S_RST_REQ);
    assign bus.o_reset_val = 1'b0;
    assign bus.o_spi_valid = (state == S_SEND);
    assign bus.o_spi_dc    = word[8];
    assign bus.o_spi_data  = word[7:0];
    assign bus.o_busy      = (state != S_IDLE) && (state != S_DONE);
    assign bus.o_init_done = (state == S_DONE);
    assign bus.o_cmd_idx   = 4'(idx);
endmodule

// File: tb/tb_ili9341_init_seq.sv
// Self-checking bench for ili9341_init_seq: directed scenarios plus randomized
// traffic, compared every cycle against a table-walking timeline model.
`timescale 1ns/1ps
module tb_ili9341_init_seq;
    localparam int CLK_PER_MS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ili9341_init_seq_if bus();

    ili9341_init_seq #(.CLK_PER_MS(CLK_PER_MS), .ROM_DEPTH(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit chk_en      = 1'b0;

    // Reference table: type 0 CMD, 1 DATA, 2 DELAY(ms), 3 END.
    int tbl_type [11] = '{0, 2, 0, 0, 1, 0, 1, 0, 2, 0, 3};
    int tbl_pay  [11] = '{'h01, 5, 'h28, 'h3A, 'h55, 'h36, 'h48, 'h11, 120, 'h29, 0};
    logic [8:0] exp_bytes [8] = '{9'h001, 9'h028, 9'h03A, 9'h155, 9'h036, 9'h148, 9'h011, 9'h029};

    function automatic int e_type(input int i);
        return (i < 11 && i < 15) ? tbl_type[i] : 3;
    endfunction

    function automatic int e_pay(input int i);
        return (i < 11) ? tbl_pay[i] : 0;
    endfunction

    typedef enum int {M_IDLE, M_RSTREQ, M_RWAIT, M_GAP, M_SEND, M_XFER, M_DONE} mphase_t;
    mphase_t m_phase = M_IDLE;
    int      m_gap   = 0;
    int      m_ptr   = 0;
    bit      m_tsend = 1'b0;

    // Every table entry costs two lookup cycles; delays add payload*CLK_PER_MS.
    function automatic void plan(input int from);
        int g = 0;
        int p = from;
        forever begin
            g += 2;
            if (e_type(p) <= 1) begin
                m_tsend = 1'b1;
                break;
            end
            if (e_type(p) == 3 || p >= 15) begin
                m_tsend = 1'b0;
                break;
            end
            g += e_pay(p) * CLK_PER_MS;
            p++;
        end
        m_ptr   = p;
        m_gap   = g;
        m_phase = M_GAP;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_phase = M_IDLE;
            m_ptr   = 0;
        end else begin
            case (m_phase)
                M_IDLE, M_DONE: if (bus.i_start) begin
                    m_phase = M_RSTREQ;
                    m_ptr   = 0;
                end
                M_RSTREQ: m_phase = M_RWAIT;
                M_RWAIT:  if (bus.i_reset_sent) plan(0);
                M_GAP: begin
                    m_gap--;
                    if (m_gap == 0) m_phase = m_tsend ? M_SEND : M_DONE;
                end
                M_SEND:   if (bus.i_spi_ready) m_phase = M_XFER;
                M_XFER:   if (bus.i_spi_done) plan(m_ptr + 1);
                default:  m_phase = M_IDLE;
            endcase
        end
    end

    logic [8:0] dut_log [$];
    always @(posedge clk) begin
        if (!rst && bus.o_spi_valid && bus.i_spi_ready) begin
            dut_log.push_back({bus.o_spi_dc, bus.o_spi_data});
        end
    end

    // Environment: panel reset block and SPI transmitter responders.
    int rst_lat = 10;
    int spi_lat = 8;
    int ready_mode = 0;
    bit noise = 1'b0;
    int hold_left = 0;
    int hold_count = 0;
    int rst_pend = -1;
    int spi_pend = -1;
    int rsent_at = -1;
    logic [7:0] pend_byte = 8'h00;
    int done_at [256];
    int rise_at [256];

    always @(negedge clk) begin
        bus.i_reset_sent = 1'b0;
        bus.i_spi_done   = 1'b0;
        if (rst) begin
            rst_pend = -1;
            spi_pend = -1;
        end
        if (bus.o_reset_ena) begin
            rst_pend = rst_lat;
        end else if (rst_pend > 0) begin
            rst_pend--;
            if (rst_pend == 0) begin
                bus.i_reset_sent = 1'b1;
                rsent_at = cyc;
                rst_pend = -1;
            end
        end else if (noise && $urandom_range(0, 29) == 0) begin
            bus.i_reset_sent = 1'b1;
        end
        if (spi_pend > 0) begin
            spi_pend--;
            if (spi_pend == 0) begin
                bus.i_spi_done = 1'b1;
                done_at[pend_byte] = cyc;
                spi_pend = -1;
            end
        end else if (noise && !bus.o_spi_valid && $urandom_range(0, 19) == 0) begin
            bus.i_spi_done = 1'b1;
        end
        case (ready_mode)
            0: bus.i_spi_ready = 1'b1;
            1: bus.i_spi_ready = ($urandom_range(0, 2) != 0);
            default: begin
                if (bus.o_spi_valid && bus.o_spi_data == 8'h3A && hold_left > 0) begin
                    bus.i_spi_ready = 1'b0;
                    hold_left--;
                    hold_count++;
                end else begin
                    bus.i_spi_ready = 1'b1;
                end
            end
        endcase
        if (bus.o_spi_valid && bus.i_spi_ready) begin
            spi_pend  = spi_lat;
            pend_byte = bus.o_spi_data;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    int   ena_count  = 0;
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("reset_ena", bus.o_reset_ena, m_phase == M_RSTREQ);
            checkOutput("reset_val", bus.o_reset_val, 0);
            checkOutput("spi_valid", bus.o_spi_valid, m_phase == M_SEND);
            checkOutput("busy", bus.o_busy, !(m_phase == M_IDLE || m_phase == M_DONE));
            checkOutput("init_done", bus.o_init_done, m_phase == M_DONE);
            if (m_phase == M_SEND) begin
                checkOutput("spi_dc", bus.o_spi_dc, e_type(m_ptr) & 1);
                checkOutput("spi_data", bus.o_spi_data, e_pay(m_ptr));
            end
            if (m_phase == M_IDLE) begin
                checkOutput("idle_dc", bus.o_spi_dc, 0);
                checkOutput("idle_data", bus.o_spi_data, 0);
            end
            if (m_phase != M_GAP) begin
                checkOutput("cmd_idx", bus.o_cmd_idx, m_ptr);
            end
            if (bus.o_reset_ena) ena_count++;
            if (bus.o_spi_valid && !prev_valid) rise_at[bus.o_spi_data] = cyc;
        end
        prev_valid = bus.o_spi_valid;
    end

    task automatic applyStimulus(input logic start_v, input logic rst_v);
        @(negedge clk);
        bus.i_start = start_v;
        rst = rst_v;
    endtask

    task automatic clearLogs();
        dut_log.delete();
        for (int i = 0; i < 256; i++) begin
            done_at[i] = -1;
            rise_at[i] = -1;
        end
        ena_count = 0;
        rsent_at  = -1;
    endtask

    task automatic pulseStart();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
    endtask

    // kind 0: init_done, 1: valid with data==arg, 2: done sent for byte arg, 3: valid at index arg
    task automatic waitFor(input int kind, input logic [7:0] arg, input int budget, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            applyStimulus(1'b0, 1'b0);
            case (kind)
                0: hit = bus.o_init_done;
                1: hit = bus.o_spi_valid && bus.o_spi_data == arg;
                2: hit = done_at[arg] >= 0;
                default: hit = bus.o_spi_valid && bus.o_cmd_idx == arg[3:0];
            endcase
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("[TB] FAIL wait_%s: got timeout after %0d cycles, expected event", name, budget);
        end
    endtask

    task automatic checkLog(input string name);
        checkOutput({name, "_len"}, dut_log.size(), 8);
        for (int i = 0; i < 8 && i < dut_log.size(); i++) begin
            checkOutput({name, "_byte"}, dut_log[i], exp_bytes[i]);
        end
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_busy"}, bus.o_busy, 0);
        checkOutput({name, "_valid"}, bus.o_spi_valid, 0);
        checkOutput({name, "_ena"}, bus.o_reset_ena, 0);
        checkOutput({name, "_done"}, bus.o_init_done, 0);
        checkOutput({name, "_dc"}, bus.o_spi_dc, 0);
        checkOutput({name, "_data"}, bus.o_spi_data, 0);
        checkOutput({name, "_idx"}, bus.o_cmd_idx, 0);
    endtask

    initial begin
        clearLogs();
        repeat (3) applyStimulus(1'b0, 1'b1);
        chk_en = 1'b1;
        checkResetOutputs("por");

        // Full sequence: ready tied high, 10-cycle reset block, 8-cycle SPI.
        pulseStart();
        waitFor(0, 8'h00, 2000, "full");
        applyStimulus(1'b0, 1'b0);
        checkLog("full");
        checkOutput("full_ena_pulses", ena_count, 1);
        checkOutput("gap_01_28", rise_at[8'h28] - done_at[8'h01], 25);
        checkOutput("gap_3A_55", rise_at[8'h55] - done_at[8'h3A], 3);
        checkOutput("gap_11_29", rise_at[8'h29] - done_at[8'h11], 485);
        checkOutput("full_done", bus.o_init_done, 1);
        checkOutput("full_idx", bus.o_cmd_idx, 10);

        // Restart from DONE with backpressure on 0x3A and a stray start at index 5.
        clearLogs();
        ready_mode = 2;
        hold_left  = 7;
        hold_count = 0;
        pulseStart();
        checkOutput("done_falls", bus.o_init_done, 0);
        waitFor(3, 8'd5, 1000, "idx5");
        pulseStart();
        waitFor(0, 8'h00, 2000, "repeat");
        applyStimulus(1'b0, 1'b0);
        checkLog("repeat");
        checkOutput("hold_cycles", hold_count, 7);
        checkOutput("repeat_ena_pulses", ena_count, 1);
        checkOutput("bp_gap_3A_55", rise_at[8'h55] - done_at[8'h3A], 3);

        // Reset block withheld for 1000 cycles, then reset mid-transfer.
        clearLogs();
        ready_mode = 0;
        rst_lat    = 1000;
        pulseStart();
        waitFor(1, 8'h01, 1100, "slow_reset");
        repeat (3) applyStimulus(1'b0, 1'b0);
        checkOutput("slow_ena_pulses", ena_count, 1);
        checkOutput("fetch_after_pulse", rise_at[8'h01] - rsent_at, 3);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        checkResetOutputs("xfer_rst");
        rst_lat = 10;

        // Reset in the middle of the 120 ms delay, then a clean full restart.
        clearLogs();
        pulseStart();
        waitFor(2, 8'h11, 1000, "delay120");
        repeat (100) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        checkResetOutputs("delay_rst");
        clearLogs();
        pulseStart();
        waitFor(0, 8'h00, 2000, "after_rst");
        applyStimulus(1'b0, 1'b0);
        checkLog("after_rst");
        checkOutput("after_rst_ena_pulses", ena_count, 1);

        // Randomized traffic: latencies, backpressure, stray pulses and resets.
        noise      = 1'b1;
        ready_mode = 1;
        for (int run = 0; run < 15; run++) begin
            rst_lat = $urandom_range(1, 20);
            spi_lat = $urandom_range(1, 12);
            pulseStart();
            for (int i = 0; i < 600; i++) begin
                applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 299) == 0);
            end
        end
        applyStimulus(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
